// File: rtl/sd_cmd_frame_rx.sv
// rtl/sd_cmd_frame_rx.sv - SD CMD-line 48-bit frame receiver with CRC7 check
// Hunts for a start bit, shifts the frame in MSB first and checks CRC7 and end bit.
module sd_cmd_frame_rx #(
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic        bitval,
  input  logic        arm,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        dirbit,
  output logic [5:0]  cmdidx,
  output logic [31:0] arg,
  output logic [6:0]  crcrx,
  output logic        crcok,
  output logic        endok
);

  typedef enum logic [1:0] {IDLE, HUNT, SHIFT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(NCR_MAX - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [5:0]  bit_cnt;
  logic [6:0]  crc;
  logic [45:0] sreg;
  logic [46:0] frame_nxt;

  // Frame bits 1..47 once the current sample is appended; [46] is bit 1, [0] is the end bit.
  assign frame_nxt = {sreg, bitval};

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic inv;
    inv = b ^ c[6];
    return {c[5], c[4], c[3], c[2] ^ inv, c[1], c[0], inv};
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      crc      <= '0;
      sreg     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      dirbit   <= 1'b0;
      cmdidx   <= '0;
      arg      <= '0;
      crcrx    <= '0;
      crcok    <= 1'b0;
      endok    <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= HUNT;
            busy     <= 1'b1;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            crc      <= '0;
          end
        end
        HUNT: begin
          if (enable) begin
            if (bitval) begin
              if (wait_cnt == WAIT_LAST) begin
                timeout <= 1'b1;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                wait_cnt <= wait_cnt + 8'd1;
              end
            end else begin
              // Start bit: it is frame bit 0, always 0, and it seeds the CRC.
              crc     <= crc7_step(crc, 1'b0);
              bit_cnt <= 6'd1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (enable) begin
            if (bit_cnt == 6'd47) begin
              dirbit <= frame_nxt[46];
              cmdidx <= frame_nxt[45:40];
              arg    <= frame_nxt[39:8];
              crcrx  <= frame_nxt[7:1];
              crcok  <= (crc == frame_nxt[7:1]);
              endok  <= bitval;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              sreg    <= frame_nxt[45:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt < 6'd40) begin
                crc <= crc7_step(crc, bitval);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_frame_rx.sv
// tb/tb_sd_cmd_frame_rx.sv - randomized self-checking bench for sd_cmd_frame_rx
module tb_sd_cmd_frame_rx;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic        bitval = 1'b1;
  logic        arm = 1'b0;
  logic        busy, done, timeout, dirbit, crcok, endok;
  logic [5:0]  cmdidx;
  logic [31:0] arg;
  logic [6:0]  crcrx;

  int          passed = 0;
  int          total = 0;
  logic [47:0] last_exp = '0;
  logic [47:0] obs;

  localparam logic [47:0] CMD0     = 48'h400000000095;
  localparam logic [47:0] CMD8     = 48'h48000001AA87;
  localparam logic [47:0] CMD8_BAD = 48'h48000001AB87;
  localparam logic [47:0] CMD8_END = 48'h48000001AA86;

  sd_cmd_frame_rx #(.NCR_MAX(64)) dut (
    .clk(clk), .clear(clear), .enable(enable), .bitval(bitval), .arm(arm),
    .busy(busy), .done(done), .timeout(timeout), .dirbit(dirbit),
    .cmdidx(cmdidx), .arg(arg), .crcrx(crcrx), .crcok(crcok), .endok(endok)
  );

  always #5 clk = ~clk;

  assign obs = {dirbit, cmdidx, arg, crcrx, crcok, endok};

  // CRC7 as the remainder of M(x)*x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_result(input logic [47:0] fr);
    logic ok;
    ok = (ref_crc7(fr[47:8]) == fr[7:1]);
    return {fr[46], fr[45:40], fr[39:8], fr[7:1], ok, fr[0]};
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] a);
    logic [39:0] m;
    m = {2'b01, idx, a};
    return {m, ref_crc7(m), 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The ARM cycle carries a sampled 0 which must not be taken as a start bit.
  task automatic do_arm();
    arm = 1'b1; enable = 1'b1; bitval = 1'b0;
    tick();
    arm = 1'b0; enable = 1'b0; bitval = 1'b1;
  endtask

  task automatic send(input logic [47:0] fr, input int pre, input int period,
                      input bit noise, input int nbits, output bit early);
    int n;
    early = 1'b0;
    n = pre + nbits;
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < period; g++) begin
        enable = 1'b0; bitval = 1'($urandom);
        arm = noise ? 1'($urandom) : 1'b0;
        tick();
        if (done || timeout) early = 1'b1;
      end
      enable = 1'b1;
      bitval = (i < pre) ? 1'b1 : fr[47 - (i - pre)];
      arm = noise ? 1'($urandom) : 1'b0;
      tick();
      if (i < n - 1 && (done || timeout)) early = 1'b1;
    end
    enable = 1'b0; arm = 1'b0; bitval = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b1; arm = 1'b1; enable = 1'b1; bitval = 1'b0;
    tick(); tick();
    clear = 1'b0; arm = 1'b0; enable = 1'b0; bitval = 1'b1;
    total++;
    if ({busy, done, timeout, obs} !== 51'b0)
      $display("FAIL reset_values got %h exp 0", {busy, done, timeout, obs});
    else passed++;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle busy got %b exp 0", busy);
    else passed++;
  endtask

  task automatic test_cmd0();
    bit early;
    logic [47:0] exp;
    do_arm();
    send(CMD0, 0, 1, 1'b0, 48, early);
    exp = ref_result(CMD0);
    total++;
    if (early !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL cmd0_latency early=%b done=%b busy=%b exp 0/1/0", early, done, busy);
    else passed++;
    total++;
    if (obs !== exp || crcrx !== 7'h4A || crcok !== 1'b1 || endok !== 1'b1)
      $display("FAIL cmd0_fields got %h exp %h", obs, exp);
    else passed++;
    last_exp = exp;
    tick();
    total++;
    if (done !== 1'b0 || obs !== last_exp)
      $display("FAIL cmd0_hold done=%b fields %h exp 0 %h", done, obs, last_exp);
    else passed++;
  endtask

  task automatic test_cmd8();
    bit early;
    logic [47:0] exp;
    do_arm();
    send(CMD8, 3, 1, 1'b0, 48, early);
    exp = ref_result(CMD8);
    total++;
    if (early !== 1'b0 || done !== 1'b1 || obs !== exp || cmdidx !== 6'd8 ||
        arg !== 32'h1AA || crcrx !== 7'h43 || crcok !== 1'b1)
      $display("FAIL cmd8 done=%b got %h exp %h", done, obs, exp);
    else passed++;
    last_exp = exp;
  endtask

  task automatic test_crc_error();
    bit early;
    logic [47:0] exp;
    do_arm();
    send(CMD8_BAD, 0, 1, 1'b0, 48, early);
    exp = ref_result(CMD8_BAD);
    total++;
    if (done !== 1'b1 || obs !== exp || crcok !== 1'b0 || crcrx !== 7'h43)
      $display("FAIL crc_error done=%b got %h exp %h", done, obs, exp);
    else passed++;
    do_arm();
    send(CMD8_END, 0, 1, 1'b0, 48, early);
    exp = ref_result(CMD8_END);
    total++;
    if (done !== 1'b1 || obs !== exp || endok !== 1'b0 || crcok !== 1'b1)
      $display("FAIL end_error done=%b got %h exp %h", done, obs, exp);
    else passed++;
    last_exp = exp;
  endtask

  task automatic test_timeout();
    bit early;
    do_arm();
    send(48'h0, 63, 1, 1'b0, 0, early);
    total++;
    if (early !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1)
      $display("FAIL timeout_early early=%b timeout=%b busy=%b exp 0/0/1", early, timeout, busy);
    else passed++;
    send(48'h0, 1, 1, 1'b0, 0, early);
    total++;
    if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || obs !== last_exp)
      $display("FAIL timeout_pulse timeout=%b busy=%b done=%b fields %h exp 1/0/0 %h",
               timeout, busy, done, obs, last_exp);
    else passed++;
    tick();
    total++;
    if (timeout !== 1'b0 || busy !== 1'b0)
      $display("FAIL timeout_after timeout=%b busy=%b exp 0/0", timeout, busy);
    else passed++;
  endtask

  task automatic test_late_start();
    bit early;
    logic [47:0] exp;
    do_arm();
    send(CMD0, 63, 1, 1'b0, 48, early);
    exp = ref_result(CMD0);
    total++;
    if (early !== 1'b0 || done !== 1'b1 || obs !== exp)
      $display("FAIL late_start early=%b done=%b got %h exp %h", early, done, obs, exp);
    else passed++;
    last_exp = exp;
  endtask

  task automatic test_clear_midframe();
    bit early;
    logic [47:0] exp;
    do_arm();
    send(CMD8, 0, 1, 1'b0, 20, early);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({busy, done, timeout, obs} !== 51'b0)
      $display("FAIL clear_mid got %h exp 0", {busy, done, timeout, obs});
    else passed++;
    last_exp = '0;
    do_arm();
    send(CMD8, 0, 1, 1'b0, 48, early);
    exp = ref_result(CMD8);
    total++;
    if (early !== 1'b0 || done !== 1'b1 || obs !== exp)
      $display("FAIL clear_recover done=%b got %h exp %h", done, obs, exp);
    else passed++;
    last_exp = exp;
  endtask

  task automatic test_gapped_enable();
    bit early;
    logic [47:0] exp;
    do_arm();
    send(CMD0, 0, 3, 1'b1, 48, early);
    exp = ref_result(CMD0);
    total++;
    if (early !== 1'b0 || done !== 1'b1 || obs !== exp)
      $display("FAIL gapped_cmd0 done=%b got %h exp %h", done, obs, exp);
    else passed++;
    do_arm();
    send(CMD8, 3, 3, 1'b1, 48, early);
    exp = ref_result(CMD8);
    total++;
    if (early !== 1'b0 || done !== 1'b1 || obs !== exp)
      $display("FAIL gapped_cmd8 done=%b got %h exp %h", done, obs, exp);
    else passed++;
    last_exp = exp;
  endtask

  task automatic test_back_to_back();
    bit early;
    logic [47:0] exp;
    do_arm();
    send(CMD8, 0, 1, 1'b0, 48, early);
    do_arm();
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_arm busy got %b exp 1", busy);
    else passed++;
    send(CMD0, 2, 1, 1'b0, 48, early);
    exp = ref_result(CMD0);
    total++;
    if (early !== 1'b0 || done !== 1'b1 || obs !== exp)
      $display("FAIL b2b_frame done=%b got %h exp %h", done, obs, exp);
    else passed++;
    last_exp = exp;
  endtask

  task automatic test_random_frames();
    bit early;
    logic [47:0] fr, exp;
    int pos;
    for (int k = 0; k < 10; k++) begin
      fr = make_frame(6'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        pos = $urandom_range(0, 46);
        fr[pos] = ~fr[pos];
      end
      do_arm();
      send(fr, $urandom_range(0, 62), $urandom_range(1, 3), 1'($urandom), 48, early);
      exp = ref_result(fr);
      total++;
      if (early !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || obs !== exp)
        $display("FAIL random_%0d done=%b frame %h got %h exp %h", k, done, fr, obs, exp);
      else passed++;
      last_exp = exp;
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_crc_error();
    test_timeout();
    test_late_start();
    test_clear_midframe();
    test_gapped_enable();
    test_back_to_back();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
